// File: rtl/traffic_pkg.sv
// Shared definitions for the emergency preemption arbiter.
// Holds the controller state encoding, the signal axis constants and the
// approach index constants, plus a small one-hot helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_HOLD    = 2'd2,
    ST_CLEAR   = 2'd3
  } preempt_state_t;

  localparam logic AXIS_13 = 1'b0;
  localparam logic AXIS_24 = 1'b1;

  localparam logic [1:0] APP_S1 = 2'd0;
  localparam logic [1:0] APP_S2 = 2'd1;
  localparam logic [1:0] APP_S3 = 2'd2;
  localparam logic [1:0] APP_S4 = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/preempt_rr_picker.sv
// Combinational round-robin picker over four emergency approaches.
// Ports:
//   cand  [3:0] in  : candidate approaches
//   ptr   [1:0] in  : first index to consider, wraps 3 -> 0
//   found       out : any candidate present
//   idx   [1:0] out : selected approach index (0 when none found)
module preempt_rr_picker
  import traffic_pkg::*;
(
  input  logic [3:0] cand,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  always_comb begin
    logic [1:0] probe;
    found = 1'b0;
    idx   = APP_S1;
    for (int k = 0; k < 4; k++) begin
      probe = ptr + 2'(k);
      if (!found && cand[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Emergency vehicle preemption arbiter for a four-approach intersection.
// Latches emergency requests, grants one approach at a time in round-robin
// order, asks the signal controller for the matching axis, holds the green
// for a bounded time, then runs a clearance interval before the next grant.
// Ports:
//   clk, rst            : system clock, async active-high reset
//   tick                : time-base strobe; all timers advance only on it
//   emg_req   [3:0]     : level emergency requests, bit i = approach S(i+1)
//   ctrl_ack            : controller confirms the requested axis is green
//   preempt_valid       : preemption request to the controller
//   preempt_axis        : 0 = S1/S3, 1 = S2/S4
//   grant     [3:0]     : one-hot granted approach
//   beacon    [3:0]     : confirmation light of the granted approach in HOLD
//   busy                : REQUEST, HOLD or CLEAR
//   timeout_err         : sticky ack-timeout flag, cleared by ctrl_ack
//
// state   | meaning
// IDLE    | no preemption; arbitrates pending requests
// REQUEST | preemption asked, waiting for ctrl_ack or timeout
// HOLD    | preemption green active, beacon on
// CLEAR   | clearance interval, no new grant
module emergency_preempt_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned HOLD_MIN    = 5,
  parameter int unsigned HOLD_MAX    = 20,
  parameter int unsigned CLEAR_TICKS = 3,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] emg_req,
  input  logic       ctrl_ack,
  output logic       preempt_valid,
  output logic       preempt_axis,
  output logic [3:0] grant,
  output logic [3:0] beacon,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [7:0] HOLD_MIN_T = 8'(HOLD_MIN);
  localparam logic [7:0] HOLD_MAX_T = 8'(HOLD_MAX);
  localparam logic [7:0] CLEAR_T    = 8'(CLEAR_TICKS);
  localparam logic [7:0] ACK_T      = 8'(ACK_TIMEOUT);

  preempt_state_t state, state_n;
  logic [7:0] timer, timer_n, timer_inc;
  logic [1:0] ptr, ptr_n;
  logic [1:0] gidx, gidx_n;
  logic [3:0] pending, pending_n;
  logic [3:0] lockout, lockout_n;
  logic [3:0] cand, clr_mask, lock_set;
  logic       pick_found;
  logic [1:0] pick_idx;

  logic       valid_n, axis_n, busy_n, err_n;
  logic [3:0] grant_n, beacon_n;

  // Locked-out approaches still count if already pending from before lockout.
  assign cand = pending | (emg_req & ~lockout);

  preempt_rr_picker u_picker (
    .cand  (cand),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n   = state;
    gidx_n    = gidx;
    ptr_n     = ptr;
    clr_mask  = 4'b0000;
    lock_set  = 4'b0000;
    err_n     = ctrl_ack ? 1'b0 : timeout_err;
    timer_inc = (timer == 8'hFF) ? timer : timer + 8'd1;

    // Interval limits are checked against the count this tick would reach,
    // so a parameter value of N ends the interval on its Nth tick.
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_n = ST_REQUEST;
          gidx_n  = pick_idx;
          ptr_n   = pick_idx + 2'd1;
        end
      end
      ST_REQUEST: begin
        if (ctrl_ack) begin
          state_n = ST_HOLD;
        end else if (tick && timer_inc >= ACK_T) begin
          state_n  = ST_IDLE;
          err_n    = 1'b1;
          clr_mask = onehot4(gidx);
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (timer_inc >= HOLD_MAX_T) begin
            state_n  = ST_CLEAR;
            clr_mask = onehot4(gidx);
            if (emg_req[gidx]) lock_set = onehot4(gidx);
          end else if (timer_inc >= HOLD_MIN_T && !emg_req[gidx]) begin
            state_n  = ST_CLEAR;
            clr_mask = onehot4(gidx);
          end
        end
      end
      ST_CLEAR: begin
        if (tick && timer_inc >= CLEAR_T) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state) timer_n = 8'd0;
    else if (tick)        timer_n = timer_inc;
    else                  timer_n = timer;

    pending_n = cand & ~clr_mask;
    lockout_n = (lockout & emg_req) | lock_set;

    valid_n  = (state_n == ST_REQUEST) || (state_n == ST_HOLD);
    axis_n   = valid_n ? (gidx_n[0] ? AXIS_24 : AXIS_13) : AXIS_13;
    grant_n  = valid_n ? onehot4(gidx_n) : 4'b0000;
    beacon_n = (state_n == ST_HOLD) ? onehot4(gidx_n) : 4'b0000;
    busy_n   = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      timer         <= 8'd0;
      ptr           <= 2'd0;
      gidx          <= 2'd0;
      pending       <= 4'b0000;
      lockout       <= 4'b0000;
      preempt_valid <= 1'b0;
      preempt_axis  <= 1'b0;
      grant         <= 4'b0000;
      beacon        <= 4'b0000;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      ptr           <= ptr_n;
      gidx          <= gidx_n;
      pending       <= pending_n;
      lockout       <= lockout_n;
      preempt_valid <= valid_n;
      preempt_axis  <= axis_n;
      grant         <= grant_n;
      beacon        <= beacon_n;
      busy          <= busy_n;
      timeout_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Self-checking bench for emergency_preempt_arbiter: directed scenarios plus
// randomized traffic, all compared cycle by cycle with a behavioural model.
module tb_emergency_preempt_arbiter;

  localparam int HOLD_MIN    = 5;
  localparam int HOLD_MAX    = 20;
  localparam int CLEAR_TICKS = 3;
  localparam int ACK_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] emg_req = 4'b0000;
  logic       ctrl_ack = 1'b0;
  logic       preempt_valid, preempt_axis, busy, timeout_err;
  logic [3:0] grant, beacon;

  int n_checks = 0;
  int n_errors = 0;
  int n_hold   = 0;
  int n_clr    = 0;

  // Behavioural model: who owns the preemption, what phase it is in, and
  // how many ticks that phase has run.
  int       m_owner;
  bit       m_acked;
  bit       m_clearing;
  int       m_cnt;
  int       m_ptr;
  bit [3:0] m_pend;
  bit [3:0] m_lock;
  bit       m_err;

  emergency_preempt_arbiter #(
    .HOLD_MIN(HOLD_MIN), .HOLD_MAX(HOLD_MAX),
    .CLEAR_TICKS(CLEAR_TICKS), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .emg_req(emg_req), .ctrl_ack(ctrl_ack),
    .preempt_valid(preempt_valid), .preempt_axis(preempt_axis), .grant(grant),
    .beacon(beacon), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_outs();
    return {preempt_valid, preempt_axis, grant, beacon, busy, timeout_err};
  endfunction

  function automatic logic [11:0] model_outs();
    logic [3:0] g, b;
    logic       v, ax, bz;
    v  = (m_owner >= 0);
    g  = v ? 4'(1 << m_owner) : 4'b0000;
    b  = (v && m_acked) ? g : 4'b0000;
    ax = v ? 1'(m_owner % 2) : 1'b0;
    bz = v || m_clearing;
    return {v, ax, g, b, bz, m_err};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_acked = 0; m_clearing = 0; m_cnt = 0;
    m_ptr = 0; m_pend = 0; m_lock = 0; m_err = 0;
  endtask

  task automatic model_step(input bit [3:0] r, input bit a, input bit t);
    bit [3:0] lock_old, clr, newly;
    lock_old = m_lock;
    clr      = 0;
    newly    = 0;
    if (a) m_err = 0;
    if (m_clearing) begin
      if (t) m_cnt++;
      if (m_cnt >= CLEAR_TICKS) m_clearing = 0;
    end else if (m_owner >= 0 && !m_acked) begin
      if (a) begin
        m_acked = 1; m_cnt = 0;
      end else if (t) begin
        m_cnt++;
        if (m_cnt >= ACK_TIMEOUT) begin
          m_err = 1; clr[m_owner] = 1; m_owner = -1;
        end
      end
    end else if (m_owner >= 0) begin
      if (t) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (m_cnt >= HOLD_MAX || (m_cnt >= HOLD_MIN && !r[m_owner])) begin
          if (r[m_owner]) newly[m_owner] = 1;
          clr[m_owner] = 1;
          m_owner = -1; m_acked = 0; m_clearing = 1; m_cnt = 0;
        end
      end
    end else begin
      bit [3:0] c;
      c = m_pend | (r & ~lock_old);
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (m_owner < 0 && c[i]) begin
          m_owner = i; m_cnt = 0; m_acked = 0;
        end
      end
      if (m_owner >= 0) m_ptr = (m_owner + 1) % 4;
    end
    m_pend = (m_pend | (r & ~lock_old)) & ~clr;
    m_lock = (lock_old & r) | newly;
  endtask

  task automatic step(input bit [3:0] r, input bit a, input bit t);
    emg_req = r; ctrl_ack = a; tick = t;
    @(posedge clk);
    model_step(r, a, t);
    @(negedge clk);
    chk("outs", 32'(dut_outs()), 32'(model_outs()));
    if (beacon != 4'b0000) n_hold++;
    if (busy && !preempt_valid) n_clr++;
  endtask

  task automatic do_reset();
    emg_req = 0; ctrl_ack = 0; tick = 0;
    rst = 1'b1;
    #1;
    chk("rst_outs", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n_hold = 0; n_clr = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 32'(dut_outs()), 32'd0);
    rst = 1'b0;

    // Single request, ack two ticks later, release on the third hold tick.
    step(4'b0000, 0, 1);
    step(4'b0001, 0, 1);
    chk("s1_grant", 32'(grant), 32'b0001);
    step(4'b0001, 0, 1);
    step(4'b0001, 1, 1);
    chk("s1_axis", 32'(preempt_axis), 32'd0);
    step(4'b0001, 0, 1);
    step(4'b0001, 0, 1);
    for (int i = 0; i < 14; i++) step(4'b0000, 0, 1);
    chk("s1_hold_len", 32'(n_hold), 32'd5);
    chk("s1_clear_len", 32'(n_clr), 32'd3);
    chk("s1_idle", 32'(busy), 32'd0);

    // Simultaneous requests from S2 and S4 at ptr 0.
    do_reset();
    step(4'b1010, 0, 1);
    chk("s2_first", 32'(grant), 32'b0010);
    chk("s2_axis", 32'(preempt_axis), 32'd1);
    step(4'b1010, 1, 1);
    for (int i = 0; i < 9; i++) step(4'b1000, 0, 1);
    chk("s2_second", 32'(grant), 32'b1000);
    step(4'b1000, 1, 1);
    for (int i = 0; i < 12; i++) step(4'b0000, 0, 1);
    step(4'b1111, 0, 1);
    chk("s2_ptr_wrap", 32'(grant), 32'b0001);

    // Stuck request on S3: hold capped, lockout until release and re-raise.
    do_reset();
    step(4'b0100, 0, 1);
    step(4'b0100, 1, 1);
    for (int i = 0; i < 40; i++) step(4'b0100, 0, 1);
    chk("s3_hold_max", 32'(n_hold), 32'd20);
    chk("s3_no_regrant", 32'(grant), 32'd0);
    step(4'b0000, 0, 1);
    step(4'b0100, 0, 1);
    chk("s3_regrant", 32'(grant), 32'b0100);

    // Ack never arrives.
    do_reset();
    step(4'b0001, 0, 1);
    for (int i = 0; i < 4; i++) step(4'b0000, 0, 1);
    chk("s4_err", 32'(timeout_err), 32'd1);
    chk("s4_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) step(4'b0000, 0, 1);
    chk("s4_pend_clr", 32'(grant), 32'd0);
    step(4'b0000, 1, 1);
    chk("s4_err_clr", 32'(timeout_err), 32'd0);

    // Reset during HOLD, asserted between edges.
    do_reset();
    step(4'b0010, 0, 1);
    step(4'b0010, 1, 1);
    step(4'b0010, 0, 1);
    step(4'b0010, 0, 1);
    emg_req = 0; ctrl_ack = 0;
    #2 rst = 1'b1;
    #1 chk("s5_async_rst", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(4'b0000, 0, 1);
    chk("s5_stays_idle", 32'(busy), 32'd0);

    // Time base stopped in HOLD.
    do_reset();
    step(4'b0001, 0, 1);
    step(4'b0001, 1, 1);
    for (int i = 0; i < 60; i++) step(4'b0000, 0, 0);
    chk("s6_frozen", 32'(beacon), 32'b0001);
    for (int i = 0; i < 15; i++) step(4'b0000, 0, 1);
    chk("s6_resume", 32'(busy), 32'd0);

    // Randomized traffic.
    do_reset();
    begin
      bit [3:0] r;
      r = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
        step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/emergency_preempt_arbiter.md
EMERGENCY_PREEMPT_ARBITER -- requirements
Module: emergency_preempt_arbiter

Interface
REQ-001 Parameter HOLD_MIN, 5: minimum preemption green, in ticks, counted from ack.
REQ-002 Parameter HOLD_MAX, 20: maximum preemption green, in ticks; HOLD_MIN < HOLD_MAX <= 255.
REQ-003 Parameter CLEAR_TICKS, 3: post-preemption clearance interval, in ticks.
REQ-004 Parameter ACK_TIMEOUT, 4: ticks allowed between request and ctrl_ack.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tick  input  1  one-clk time-base strobe; all timers advance only on clk edges where tick=1.
REQ-008 emg_req  input  4  level emergency requests, bit i = approach S(i+1).
REQ-009 ctrl_ack  input  1  signal controller confirms the requested axis is green.
REQ-010 preempt_valid  output  1  preemption request to signal controller.
REQ-011 preempt_axis  output  1  0 = S1/S3 axis, 1 = S2/S4 axis; equals bit 0 of the granted index.
REQ-012 grant  output  4  one-hot granted approach, zero when none.
REQ-013 beacon  output  4  confirmation light, bit i high only in HOLD for granted approach i.
REQ-014 busy  output  1  high in REQUEST, HOLD and CLEAR.
REQ-015 timeout_err  output  1  sticky; set on ack timeout, cleared on the next ctrl_ack or on reset.

Function
REQ-016 FSM states: IDLE, REQUEST, HOLD, CLEAR; all outputs registered.
REQ-017 pending[i] sets on any edge with emg_req[i]=1 and lockout[i]=0; it clears when approach i leaves HOLD or times out.
REQ-018 IDLE: if (pending | (emg_req & ~lockout)) is nonzero, go to REQUEST on that edge, with preempt_valid and grant valid from the same edge (1-cycle latency from the sampled request).
REQ-019 Round-robin arbitration: pick the first candidate at index >= ptr, wrapping 3->0; on grant, ptr <= (index+1) mod 4; ptr resets to 0.
REQ-020 REQUEST: hold preempt_valid=1 and grant stable; on ctrl_ack=1 go to HOLD with timer=0.
REQ-021 REQUEST timeout: when the tick count reaches ACK_TIMEOUT without ack, set timeout_err, clear pending for the granted approach, drop grant/preempt_valid and go to IDLE.
REQ-022 HOLD: preempt_valid=1 and beacon active; exit to CLEAR when (timer >= HOLD_MIN and emg_req[granted]=0) or timer >= HOLD_MAX.
REQ-023 Exit on HOLD_MAX with emg_req[granted] still high sets lockout[granted]; lockout[i] clears on the first edge with emg_req[i]=0.
REQ-024 CLEAR: preempt_valid=0, grant=0, busy=1; after CLEAR_TICKS ticks go to IDLE; no new grant is issued during CLEAR.
REQ-025 New requests from other approaches during REQUEST, HOLD or CLEAR are latched in pending only and never alter the current grant.
REQ-026 The granted approach re-raising its request in HOLD has no effect.
REQ-027 Timer is 8 bits, saturates at 255 and is zeroed on every state entry.
REQ-028 Comparisons use >= so the parameter value itself terminates the interval.
REQ-029 ctrl_ack seen outside REQUEST is ignored except for clearing timeout_err.

Reset
REQ-030 Reset forces, asynchronously: state=IDLE, timer=0, ptr=0, pending=0, lockout=0, and all outputs 0.
REQ-031 Reset asserted mid-preemption drops preempt_valid within the reset assertion; no resumption occurs after release.

Structure
REQ-032 Shared package traffic_pkg holds the FSM state encoding, the axis constants AXIS_13/AXIS_24 and the approach index constants.
REQ-033 Round-robin selection is a combinational sub-module preempt_rr_picker (inputs: 4-bit candidates and 2-bit ptr; outputs: found, 2-bit index).

Verification (defaults, tick every cycle)
REQ-034 emg_req=0001, ack 2 ticks later, release at tick 3 -> HOLD lasts 5 ticks, then CLEAR 3 ticks, then IDLE; preempt_axis=0 and beacon=0001 throughout HOLD.
REQ-035 emg_req=1010 simultaneously at ptr=0 -> approach 1 granted first, then approach 3 after CLEAR; ptr=0 after both.
REQ-036 emg_req[2] held high permanently -> HOLD ends at tick 20, lockout[2]=1, no regrant until the request drops and rises again.
REQ-037 Request with ctrl_ack never asserted -> timeout_err=1 after 4 ticks, FSM returns to IDLE, pending bit cleared; next ack clears timeout_err.
REQ-038 rst pulsed in HOLD -> all outputs 0 immediately; after release, with no requests, the block stays IDLE.
REQ-039 tick held 0 in HOLD -> timer frozen and the state is held indefinitely.
